// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: load-use bubbles, branch squash window, dmem waits.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned REDIRECT_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_uses_rs1,
  input  logic        dec_uses_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        nop_output,
  output logic        flush_if,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    BAD      = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(REDIRECT_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       luh, mw;
  logic       s_if, s_id, s_ex, s_nop, s_flush;

  assign luh = dec_valid & ex_valid & ex_is_load & (ex_rd != '0) &
               ((dec_uses_rs1 & (dec_rs1 == ex_rd)) | (dec_uses_rs2 & (dec_rs2 == ex_rd)));
  assign mw  = mem_req & ~mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_if    = 1'b0;
    s_id    = 1'b0;
    s_ex    = 1'b0;
    s_nop   = 1'b0;
    s_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (mw) begin
          s_if    = 1'b1;
          s_id    = 1'b1;
          s_ex    = 1'b1;
          state_d = MEM_WAIT;
        end else if (ex_branch_taken) begin
          s_flush = 1'b1;
          s_nop   = 1'b1;
          cnt_d   = CNT_LOAD;
          if (REDIRECT_LAT > 1) state_d = FLUSH;
        end else if (luh) begin
          s_if  = 1'b1;
          s_id  = 1'b1;
          s_nop = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Branch and load-use are held in the frozen EX stage and re-present in RUN.
        if (mw) begin
          s_if = 1'b1;
          s_id = 1'b1;
          s_ex = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        s_flush = 1'b1;
        s_nop   = 1'b1;
        if (mw) begin
          s_if = 1'b1;
          s_id = 1'b1;
          s_ex = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign stall_if   = rst_n & s_if;
  assign stall_id   = rst_n & s_id;
  assign stall_ex   = rst_n & s_ex;
  assign nop_output = rst_n & s_nop;
  assign flush_if   = rst_n & s_flush;
  assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_if && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage RISC-V pipeline. Every cycle it decides whether the IF/ID and ID/EX pipeline registers advance, hold, or take a bubble, and drives the `nop_output` input of `pipeline_dec`. Three conditions are sequenced:
- load-use hazards;
- taken-branch redirects, including a multi-cycle squash window;
- data-memory wait states.

It is the single arbiter of pipeline flow control.

## Interface
Parameters:
- `REDIRECT_LAT`, default 2: cycles, including the branch cycle, during which the IF/ID contents are wrong-path. Legal range 1..15.

Ports:
- `clk` input 1: pipeline clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `dec_valid` input 1: valid instruction present in decode.
- `dec_rs1`, `dec_rs2` input 5 each: decode source register indices.
- `dec_uses_rs1`, `dec_uses_rs2` input 1 each: instruction actually reads rs1/rs2.
- `ex_valid` input 1: valid instruction in EX.
- `ex_rd` input 5: EX destination register.
- `ex_is_load` input 1: EX instruction is a load.
- `ex_branch_taken` input 1: EX resolved a taken branch or jump this cycle.
- `mem_req` input 1: MEM stage has an outstanding data-memory access.
- `mem_ready` input 1: data memory completes the access this cycle.
- `stall_if` output 1: hold PC and IF/ID.
- `stall_id` output 1: hold decode stage / ID/EX inputs.
- `stall_ex` output 1: hold EX/MEM.
- `nop_output` output 1: load a bubble into ID/EX.
- `flush_if` output 1: squash the fetched instruction entering IF/ID.
- `ctrl_state` output 2: current FSM state, for debug.
- `stall_cycles` output 32: performance counter; see Configuration.
- `flush_cycles` output 32: performance counter; see Configuration.

## Operation
- FSM states and encodings: RUN=0, MEM_WAIT=1, FLUSH=2. Encoding 3 is unreachable; if entered, the FSM returns to RUN on the next edge.
- Outputs are Mealy: they are combinational from the registered state and the current inputs.
- Load-use hazard `luh` is asserted when all of the following hold:
  - `dec_valid`, `ex_valid` and `ex_is_load` are all 1;
  - `ex_rd` is not 0;
  - (`dec_uses_rs1` and `dec_rs1` equals `ex_rd`) or (`dec_uses_rs2` and `dec_rs2` equals `ex_rd`).
- Memory wait `mw` is asserted when `mem_req` is 1 and `mem_ready` is 0.
- RUN, evaluated in priority order:
  1. `mw`: assert `stall_if`, `stall_id` and `stall_ex`. `nop_output` is 0. Next state MEM_WAIT.
  2. `ex_branch_taken`: assert `flush_if` and `nop_output`; the stalls are 0. Load the squash counter with `REDIRECT_LAT`-1. Next state is FLUSH if `REDIRECT_LAT` is greater than 1, otherwise RUN.
  3. `luh`: assert `stall_if`, `stall_id` and `nop_output`; `stall_ex` is 0. Stay in RUN. The bubble clears the hazard on the next cycle, so exactly one bubble is inserted per load-use pair.
  4. Otherwise all outputs are 0.
- MEM_WAIT:
  - While `mw`, `stall_if`, `stall_id` and `stall_ex` are 1.
  - When `mem_ready` is 1, all stalls are 0 in that same cycle and the next state is RUN.
  - `ex_branch_taken` and `luh` are ignored. EX is frozen, so they re-present in RUN.
- FLUSH:
  - `flush_if` and `nop_output` are 1.
  - The counter decrements each cycle; when it reaches 1, the next state is RUN.
  - If `mw`: the stalls are also asserted and the counter holds.
  - `ex_branch_taken` is ignored, because EX holds bubbles.

## Timing
- Zero-cycle control latency: a hazard input affects the outputs in the same cycle.
- The state and the counter update on the rising edge of `clk`.
- Load-use: one bubble cycle, then decode proceeds.
- Branch: `REDIRECT_LAT` consecutive cycles of `flush_if`/`nop_output`, extended by any overlapping memory-wait cycles.
- Reset:
  - `rst_n` low asynchronously forces state to RUN, the counter to 0 and both perf counters to 0.
  - While `rst_n` is low, all control outputs are 0.
  - Reset asserted mid-FLUSH or mid-MEM_WAIT abandons that operation with no residual squash after release.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` counts cycles with `stall_if` set.
  - `flush_cycles` counts cycles with `flush_if` set.
  - Both saturate at 0xFFFFFFFF.
- Macro not defined: both ports are present and tied to 0, and no counter flops are built.

## Test plan
- Load-use hazard: EX load with `ex_rd`=5 and decode `dec_rs2`=5 with `dec_uses_rs2`=1. Required: exactly one cycle of `stall_if`=`stall_id`=`nop_output`=1, then all outputs 0 once EX shows the bubble. Repeat with `ex_rd`=0: no stall.
- Branch squash: `ex_branch_taken` pulses one cycle with `REDIRECT_LAT`=2. Required: `flush_if`=`nop_output`=1 for 2 cycles; `ctrl_state` sequence RUN→FLUSH→RUN. Repeat with `REDIRECT_LAT`=1: 1 cycle, state stays RUN.
- Memory wait: `mem_req`=1 with `mem_ready` low for 3 cycles, then high. Required: all three stalls are 1 for 3 cycles and 0 in the ready cycle; state MEM_WAIT for 3 cycles, then RUN.
- Priority: `mw`, `ex_branch_taken` and `luh` all asserted together in RUN. Required: MEM_WAIT stalls only, no flush. After `mem_ready`, the held branch produces the flush.
- Memory wait inside FLUSH: `mw` asserted for 2 cycles during FLUSH with `REDIRECT_LAT`=3. Required: total of 5 `flush_if` cycles, with the counter frozen during the wait.
- Reset and counters: `rst_n` driven low mid-FLUSH. Required: outputs immediately 0, state RUN, no flush after release. With `HAZARD_PERF_CNT_EN` defined, the counters read 0 after reset and increment by exactly the number of stall and flush cycles in the scenarios above.
